// File: rtl/fir_stage_sequencer.sv
// fir_stage_sequencer: block-level ap_ctrl_hs sequencer for the FIR core.
// Runs the shift loop, then the MAC loop, latches latencies, guards stalls.
module fir_stage_sequencer #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             ap_start,
   output logic             ap_done,
   output logic             ap_idle,
   output logic             ap_ready,
   output logic             shift_start,
   input  logic             shift_ready,
   input  logic             shift_done,
   output logic             mac_start,
   input  logic             mac_ready,
   input  logic             mac_done,
   input  logic             err_clear,
   output logic             err_timeout,
   output logic [CNT_W-1:0] shift_cycles,
   output logic [CNT_W-1:0] mac_cycles,
   output logic [CNT_W-1:0] total_cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_MAC,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam bit               WD_EN   = (TIMEOUT > 0);
   localparam logic [63:0]      TO_VAL  = 64'(TIMEOUT);

   state_t           state_q, state_d;
   logic             ack_q, ack_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] shift_lat_q, shift_lat_d;
   logic [CNT_W-1:0] shift_cyc_q, shift_cyc_d;
   logic [CNT_W-1:0] mac_cyc_q, mac_cyc_d;
   logic [CNT_W-1:0] total_cyc_q, total_cyc_d;

   logic             stage_done;
   logic             stage_ready;
   logic [CNT_W-1:0] cnt_inc;
   logic             wd_hit;

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] a,
      input logic [CNT_W-1:0] b
   );
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
   endfunction

   // route the live sub-block handshake for the current stage
   always_comb begin
      stage_done  = 1'b0;
      stage_ready = 1'b0;
      unique case (1'b1)
         (state_q == S_SHIFT): begin
            stage_done  = shift_done;
            stage_ready = shift_ready;
         end
         (state_q == S_MAC): begin
            stage_done  = mac_done;
            stage_ready = mac_ready;
         end
         default: ;
      endcase
   end

   // stage count including this cycle, and the watchdog trip on it
   always_comb begin
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      wd_hit  = WD_EN && (64'(cnt_inc) >= TO_VAL);
   end

   // next-state, handshake and latency latching
   always_comb begin
      state_d     = state_q;
      ack_d       = ack_q;
      cnt_d       = cnt_q;
      shift_lat_d = shift_lat_q;
      shift_cyc_d = shift_cyc_q;
      mac_cyc_d   = mac_cyc_q;
      total_cyc_d = total_cyc_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            ack_d = 1'b0;
            if (ap_start) state_d = S_SHIFT;
         end
         S_SHIFT, S_MAC: begin
            cnt_d = cnt_inc;
            if (stage_ready) ack_d = 1'b1;
            if (stage_done) begin
               cnt_d = '0;
               ack_d = 1'b0;
               if (state_q == S_SHIFT) begin
                  shift_lat_d = cnt_inc;
                  state_d     = S_MAC;
               end else begin
                  shift_cyc_d = shift_lat_q;
                  mac_cyc_d   = cnt_inc;
                  total_cyc_d = sat_add(shift_lat_q, cnt_inc);
                  state_d     = S_DONE;
               end
            end else if (wd_hit) begin
               state_d = S_ERR;
            end
         end
         S_DONE: state_d = S_IDLE;
         S_ERR: begin
            if (err_clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and counter registers, synchronous reset
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= S_IDLE;
         ack_q       <= 1'b0;
         cnt_q       <= '0;
         shift_lat_q <= '0;
         shift_cyc_q <= '0;
         mac_cyc_q   <= '0;
         total_cyc_q <= '0;
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         cnt_q       <= cnt_d;
         shift_lat_q <= shift_lat_d;
         shift_cyc_q <= shift_cyc_d;
         mac_cyc_q   <= mac_cyc_d;
         total_cyc_q <= total_cyc_d;
      end
   end

   assign ap_idle      = (state_q == S_IDLE);
   assign ap_done      = (state_q == S_DONE);
   assign ap_ready     = (state_q == S_DONE);
   assign err_timeout  = (state_q == S_ERR);
   assign shift_start  = (state_q == S_SHIFT) && !ack_q;
   assign mac_start    = (state_q == S_MAC) && !ack_q;
   assign shift_cycles = shift_cyc_q;
   assign mac_cycles   = mac_cyc_q;
   assign total_cycles = total_cyc_q;

endmodule

// File: tb/tb_fir_stage_sequencer.sv
// tb_fir_stage_sequencer: table runs plus corner sequences, scoreboard on
// ap_done. Instance a uses the default watchdog, instance b TIMEOUT=8.
module tb_fir_stage_sequencer;

   typedef struct {
      int sr; int sd; int mr; int md;
      int es; int em; int et;
   } vec_t;

   typedef struct {
      int sh; int mc; int tot;
   } exp_t;

   logic ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic ap_rst, ap_start, err_clear, force_md_b;

   logic ap_done_a, ap_idle_a, ap_ready_a, err_timeout_a;
   logic shift_start_a, shift_ready_a, shift_done_a;
   logic mac_start_a, mac_ready_a, mac_done_a;
   logic [15:0] shift_cycles_a, mac_cycles_a, total_cycles_a;

   logic ap_done_b, ap_idle_b, ap_ready_b, err_timeout_b;
   logic shift_start_b, shift_ready_b, shift_done_b;
   logic mac_start_b, mac_ready_b, mac_done_b;
   logic [15:0] shift_cycles_b, mac_cycles_b, total_cycles_b;

   fir_stage_sequencer dut_a (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done_a), .ap_idle(ap_idle_a), .ap_ready(ap_ready_a),
      .shift_start(shift_start_a), .shift_ready(shift_ready_a),
      .shift_done(shift_done_a), .mac_start(mac_start_a),
      .mac_ready(mac_ready_a), .mac_done(mac_done_a),
      .err_clear(err_clear), .err_timeout(err_timeout_a),
      .shift_cycles(shift_cycles_a), .mac_cycles(mac_cycles_a),
      .total_cycles(total_cycles_a)
   );

   fir_stage_sequencer #(.CNT_W(16), .TIMEOUT(8)) dut_b (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done_b), .ap_idle(ap_idle_b), .ap_ready(ap_ready_b),
      .shift_start(shift_start_b), .shift_ready(shift_ready_b),
      .shift_done(shift_done_b), .mac_start(mac_start_b),
      .mac_ready(mac_ready_b), .mac_done(mac_done_b),
      .err_clear(err_clear), .err_timeout(err_timeout_b),
      .shift_cycles(shift_cycles_b), .mac_cycles(mac_cycles_b),
      .total_cycles(total_cycles_b)
   );

   // sub-block models: ready in stage cycle R, done in stage cycle D (0=never)
   int sh_r, sh_d, mc_r, mc_d;
   int sk_a = 0, mk_a = 0, sk_b = 0, mk_b = 0;
   logic sa_a = 1'b0, ma_a = 1'b0, sa_b = 1'b0, ma_b = 1'b0;
   int ksa, kma, ksb, kmb;

   function automatic int kof(logic act, int n, logic st);
      return act ? n + 1 : (st ? 1 : 0);
   endfunction

   always_comb begin
      ksa = kof(sa_a, sk_a, shift_start_a);
      kma = kof(ma_a, mk_a, mac_start_a);
      shift_ready_a = (ksa != 0) && (ksa == sh_r);
      shift_done_a  = (ksa != 0) && (ksa == sh_d);
      mac_ready_a   = (kma != 0) && (kma == mc_r);
      mac_done_a    = (kma != 0) && (kma == mc_d);
   end

   always_comb begin
      ksb = kof(sa_b, sk_b, shift_start_b);
      kmb = kof(ma_b, mk_b, mac_start_b);
      shift_ready_b = (ksb != 0) && (ksb == sh_r);
      shift_done_b  = (ksb != 0) && (ksb == sh_d);
      mac_ready_b   = (kmb != 0) && (kmb == mc_r);
      mac_done_b    = ((kmb != 0) && (kmb == mc_d)) || force_md_b;
   end

   always @(posedge ap_clk) begin
      if (ap_rst || err_timeout_a) begin
         sa_a <= 1'b0; sk_a <= 0; ma_a <= 1'b0; mk_a <= 0;
      end else begin
         if (ksa != 0) begin
            sa_a <= !shift_done_a;
            sk_a <= shift_done_a ? 0 : ksa;
         end
         if (kma != 0) begin
            ma_a <= !mac_done_a;
            mk_a <= mac_done_a ? 0 : kma;
         end
      end
   end

   always @(posedge ap_clk) begin
      if (ap_rst || err_timeout_b) begin
         sa_b <= 1'b0; sk_b <= 0; ma_b <= 1'b0; mk_b <= 0;
      end else begin
         if (ksb != 0) begin
            sa_b <= !shift_done_b;
            sk_b <= shift_done_b ? 0 : ksb;
         end
         if (kmb != 0) begin
            ma_b <= !mac_done_b;
            mk_b <= mac_done_b ? 0 : kmb;
         end
      end
   end

   int n_cmp = 0, n_bad = 0;
   int n_done_a = 0, n_done_b = 0, sst_a = 0, mst_a = 0;
   exp_t sb_q[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // scoreboard: every ap_done of instance a pops one expected latency set
   always @(negedge ap_clk) begin
      exp_t e;
      if (ap_done_a) begin
         n_done_a++;
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_shift_cycles", shift_cycles_a, e.sh);
            chk("sb_mac_cycles", mac_cycles_a, e.mc);
            chk("sb_total_cycles", total_cycles_a, e.tot);
            chk("sb_ap_ready", ap_ready_a, 1);
         end
      end
      if (ap_done_b) n_done_b++;
      if (shift_start_a) sst_a++;
      if (mac_start_a) mst_a++;
   end

   task automatic set_cfg(input int sr, input int sd, input int mr, input int md);
      sh_r = sr; sh_d = sd; mc_r = mr; mc_d = md;
   endtask

   task automatic do_reset();
      ap_rst = 1'b1;
      repeat (2) @(negedge ap_clk);
      ap_rst = 1'b0;
      @(negedge ap_clk);
   endtask

   task automatic run_a(input vec_t v, input string nm);
      int base;
      bit seen;
      set_cfg(v.sr, v.sd, v.mr, v.md);
      sb_q.push_back('{v.es, v.em, v.et});
      base = n_done_a;
      sst_a = 0;
      mst_a = 0;
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         if (ap_done_a) seen = 1'b1;
         else @(negedge ap_clk);
      end
      chk({nm, "_done_seen"}, seen, 1);
      repeat (2) @(negedge ap_clk);
      chk({nm, "_done_pulses"}, n_done_a - base, 1);
      chk({nm, "_shift_start_len"}, sst_a, v.sr);
      chk({nm, "_mac_start_len"}, mst_a, v.mr);
      chk({nm, "_idle_after"}, ap_idle_a, 1);
   endtask

   vec_t tbl[5];
   int   cyc, dn, base_b;

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1, 3, 1, 15, 3, 15, 18};
      tbl[1] = '{1, 1, 1, 2, 1, 2, 3};
      tbl[2] = '{2, 5, 3, 3, 5, 3, 8};
      tbl[3] = '{1, 1, 1, 1, 1, 1, 2};
      tbl[4] = '{4, 10, 2, 40, 10, 40, 50};

      ap_rst = 1'b1;
      ap_start = 1'b0;
      err_clear = 1'b0;
      force_md_b = 1'b0;
      set_cfg(1, 3, 1, 15);

      // reset state, while held and right after release
      repeat (2) @(negedge ap_clk);
      chk("rst_idle", ap_idle_a, 1);
      chk("rst_done", ap_done_a, 0);
      chk("rst_ready", ap_ready_a, 0);
      chk("rst_shift_start", shift_start_a, 0);
      chk("rst_mac_start", mac_start_a, 0);
      chk("rst_err", err_timeout_a, 0);
      chk("rst_shift_cycles", shift_cycles_a, 0);
      chk("rst_mac_cycles", mac_cycles_a, 0);
      chk("rst_total_cycles", total_cycles_a, 0);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("post_rst_idle", ap_idle_a, 1);
      chk("post_rst_err_b", err_timeout_b, 0);

      // table-driven runs
      for (int i = 0; i < 5; i++) run_a(tbl[i], $sformatf("vec%0d", i));

      // same-cycle ready and done in the first shift cycle
      set_cfg(1, 1, 1, 2);
      sb_q.push_back('{1, 2, 3});
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      chk("same_shift_start", shift_start_a, 1);
      chk("same_shift_done", shift_done_a, 1);
      chk("same_mac_start_early", mac_start_a, 0);
      @(negedge ap_clk);
      chk("same_mac_start", mac_start_a, 1);
      chk("same_shift_start_off", shift_start_a, 0);
      cyc = 0;
      while (!ap_done_a && cyc < 50) begin
         @(negedge ap_clk);
         cyc++;
      end
      chk("same_done_seen", ap_done_a, 1);
      repeat (2) @(negedge ap_clk);

      // held start: three runs, one idle cycle between each
      set_cfg(1, 2, 1, 2);
      repeat (3) sb_q.push_back('{2, 2, 4});
      dn = 0;
      ap_start = 1'b1;
      for (int c = 0; c < 80 && dn < 3; c++) begin
         @(negedge ap_clk);
         if (ap_done_a) begin
            dn++;
            if (dn == 3) ap_start = 1'b0;
            @(negedge ap_clk);
            chk("held_gap_idle", ap_idle_a, 1);
            @(negedge ap_clk);
            chk("held_after_gap_idle", ap_idle_a, dn == 3);
            chk("held_after_gap_start", shift_start_a, dn < 3);
         end
      end
      ap_start = 1'b0;
      chk("held_runs", dn, 3);
      repeat (2) @(negedge ap_clk);

      // timeout on instance b (TIMEOUT=8)
      do_reset();
      run_a('{1, 2, 1, 3, 2, 3, 5}, "pre_to");
      chk("pre_to_b_shift", shift_cycles_b, 2);
      chk("pre_to_b_mac", mac_cycles_b, 3);
      chk("pre_to_b_total", total_cycles_b, 5);
      set_cfg(1, 2, 1, 0);
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      cyc = 1;
      while (!err_timeout_b && cyc < 100) begin
         @(negedge ap_clk);
         cyc++;
      end
      chk("to_err_cycle", cyc, 11);
      chk("to_err", err_timeout_b, 1);
      chk("to_mac_start", mac_start_b, 0);
      chk("to_shift_start", shift_start_b, 0);
      chk("to_done", ap_done_b, 0);
      chk("to_ready", ap_ready_b, 0);
      chk("to_keep_shift", shift_cycles_b, 2);
      chk("to_keep_mac", mac_cycles_b, 3);
      chk("to_keep_total", total_cycles_b, 5);
      base_b = n_done_b;
      force_md_b = 1'b1;
      @(negedge ap_clk);
      force_md_b = 1'b0;
      @(negedge ap_clk);
      chk("to_late_done_err", err_timeout_b, 1);
      chk("to_late_done_pulse", n_done_b - base_b, 0);
      chk("to_late_done_mac", mac_cycles_b, 3);
      err_clear = 1'b1;
      @(negedge ap_clk);
      err_clear = 1'b0;
      chk("to_clear_idle", ap_idle_b, 1);
      chk("to_clear_err", err_timeout_b, 0);

      // watchdog boundary: done in the 8th MAC cycle wins
      do_reset();
      base_b = n_done_b;
      run_a('{1, 2, 1, 8, 2, 8, 10}, "wd_edge");
      chk("wd_edge_b_done", n_done_b - base_b, 1);
      chk("wd_edge_b_mac", mac_cycles_b, 8);
      chk("wd_edge_b_total", total_cycles_b, 10);
      chk("wd_edge_b_err", err_timeout_b, 0);
      chk("wd_edge_b_idle", ap_idle_b, 1);

      // reset in the 2nd MAC cycle
      do_reset();
      set_cfg(1, 2, 1, 15);
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      @(negedge ap_clk);
      @(negedge ap_clk);
      chk("mid_rst_mac1", mac_start_a, 1);
      @(negedge ap_clk);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      chk("mid_rst_idle", ap_idle_a, 1);
      chk("mid_rst_mac_start", mac_start_a, 0);
      chk("mid_rst_done", ap_done_a, 0);
      chk("mid_rst_shift", shift_cycles_a, 0);
      chk("mid_rst_mac", mac_cycles_a, 0);
      chk("mid_rst_total", total_cycles_a, 0);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      run_a(tbl[3], "after_rst");

      chk("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fir_stage_sequencer.md
Name: fir_stage_sequencer

Overview:
- Top-level block-level control sequencer for the FIR core.
- Accepts an ap_ctrl_hs-style start from the testbench or host and runs the two pipelined sub-loops strictly in order: the shift-register loop first, then the MAC loop.
- Produces top-level ap_done, ap_idle and ap_ready.
- Keeps per-stage cycle counters and a timeout watchdog so the dataflow and loop monitors can cross-check latency.

Parameters:
- CNT_W, 16: width of the cycle counters.
- TIMEOUT, 1024: maximum number of cycles in one stage before error. 0 disables the watchdog.

Ports:
- ap_clk, in, 1: clock.
- ap_rst, in, 1: synchronous reset, active-high.
- ap_start, in, 1: top-level start request.
- ap_done, out, 1: one-cycle pulse, transaction complete.
- ap_idle, out, 1: sequencer is in IDLE.
- ap_ready, out, 1: one-cycle pulse, ready for the next ap_start.
- shift_start, out, 1: ap_start to the shift-loop sub-block.
- shift_ready, in, 1: ap_ready from the shift-loop sub-block.
- shift_done, in, 1: ap_done from the shift-loop sub-block.
- mac_start, out, 1: ap_start to the MAC-loop sub-block.
- mac_ready, in, 1: ap_ready from the MAC-loop sub-block.
- mac_done, in, 1: ap_done from the MAC-loop sub-block.
- err_clear, in, 1: acknowledge a timeout and leave ERR.
- err_timeout, out, 1: a stage exceeded TIMEOUT.
- shift_cycles, out, CNT_W: latched shift-stage latency of the last completed run.
- mac_cycles, out, CNT_W: latched MAC-stage latency of the last completed run.
- total_cycles, out, CNT_W: latched shift_cycles + mac_cycles.

Behaviour:
- One clock domain (ap_clk). Reset is synchronous and active-high on ap_rst; it takes effect only on the rising edge of ap_clk.
- States: IDLE, SHIFT, MAC, DONE, ERR. ap_rst has priority in every state and forces IDLE.
- Output values while reset is applied and immediately after it:
  - All outputs are 0 except ap_idle=1.
  - Latched counters are 0.
- ap_idle is decoded combinationally from the state: it is 1 only in IDLE.
- IDLE:
  - ap_start=1 sampled on a rising edge moves the FSM to SHIFT on the next cycle.
  - shift_done and mac_done are ignored.
- SHIFT:
  - shift_start is 1 from the first SHIFT cycle and is held until the cycle in which shift_ready=1 is sampled. It drops the following cycle and is never reasserted in the same run.
  - The stage counter increments every SHIFT cycle, including the cycle in which shift_done is sampled. A sub-block that returns done in its first cycle therefore gives a count of 1.
  - shift_done=1 moves the FSM to MAC. shift_done and shift_ready in the same cycle is legal.
  - mac_done is ignored in this state.
- MAC: identical rules to SHIFT, using mac_start, mac_ready and mac_done. mac_done=1 moves the FSM to DONE.
- DONE: lasts exactly one cycle.
  - ap_done=1 and ap_ready=1 in this cycle.
  - shift_cycles, mac_cycles and total_cycles update in this cycle and hold until the next DONE.
  - The FSM always returns to IDLE. A back-to-back ap_start is accepted from IDLE, so the minimum gap between runs is one IDLE cycle.
- Once a run has been accepted, ap_start is ignored until IDLE.
- Counters saturate at 2^CNT_W-1. total_cycles is a saturating add.
- Watchdog (TIMEOUT>0):
  - If the stage counter reaches TIMEOUT and done has not been sampled in that cycle, the next state is ERR.
  - Done arriving in the same cycle the count reaches TIMEOUT wins, and the FSM advances normally.
- ERR:
  - err_timeout=1; shift_start=0 and mac_start=0; ap_done and ap_ready stay 0.
  - Latched counters keep their previous values.
  - err_clear=1 moves the FSM to IDLE and clears err_timeout on the next cycle.
  - Late done inputs are ignored.
- Reset mid-run: the FSM returns to IDLE, starts are deasserted and nothing is latched. Whether the sub-blocks need their own reset is outside this block.

Test Plan:
- Basic run: after reset, check ap_idle=1 and all other outputs 0. Pulse ap_start for 1 cycle. Shift model: ready after 1 cycle, done after 3. MAC model: ready after 1 cycle, done after 15. Required: shift_start high for exactly 1 cycle; ap_done pulses once; shift_cycles=3, mac_cycles=15, total_cycles=18.
- Same-cycle ready and done: the shift model asserts shift_ready and shift_done together in the first cycle. Required: shift_cycles=1, and mac_start rises on the next cycle.
- Held start: keep ap_start=1 continuously for 3 runs. Required: 3 ap_done pulses; each DONE is followed by exactly one IDLE cycle (ap_idle=1) before SHIFT.
- Timeout: TIMEOUT=8 and mac_done is never asserted. Required: err_timeout=1 after 8 MAC cycles; mac_start=0; counters unchanged. A later mac_done is ignored. err_clear=1 gives ap_idle=1 on the next cycle.
- Watchdog boundary: TIMEOUT=8 and mac_done arrives in the 8th MAC cycle. Required: the FSM reaches DONE with mac_cycles=8 and err_timeout stays 0.
- Reset mid-run: assert ap_rst in the 2nd MAC cycle. Required: next cycle ap_idle=1, mac_start=0, ap_done=0, and the latched counters hold their reset value of 0.
